sy_ppl_rat: RTL
===============

SY_PPL_RAT -- requirements
Module: sy_ppl_rat

Interface
REQ-001 The block SHALL have parameter PHY_REG_NUM, default 32, giving the number of physical registers; PHY_REG_WTH = clog2(PHY_REG_NUM).
REQ-002 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_i  in  1  reset, synchronous and active-high.
REQ-004 flush_i  in  1  exception or mispredict flush.
REQ-005 dec_valid_i / dec_ready_o  in/out  1/1  decode handshake.
REQ-006 dec_rs1_idx_i, dec_rs2_idx_i, dec_rd_idx_i  in  5 each  architectural source and destination indices.
REQ-007 dec_rd_en_i  in  1  instruction writes rd.
REQ-008 fl_rdst_en_o  out  1  allocation request to the free list; fl_arc_rdst_idx_o  out  5  architectural rd.
REQ-009 fl_phy_rdst_idx_i  in  PHY_REG_WTH  allocated physical register; fl_stall_i  in  1  no free register.
REQ-010 ren_valid_o / dis_ready_i  out/in  1/1  rename-to-dispatch handshake.
REQ-011 ren_phy_rs1_o, ren_phy_rs2_o, ren_phy_rd_o, ren_old_phy_rd_o  out  PHY_REG_WTH each; ren_arc_rd_o  out  5; ren_rd_en_o  out  1.
REQ-012 rob_retire_en_i  in  1; rob_retire_arc_i  in  5; rob_retire_phy_i  in  PHY_REG_WTH  committed mapping.

Function
REQ-013 The block SHALL hold a speculative map table (spec_rat) and an architectural map table (arch_rat), each 32 x PHY_REG_WTH.
REQ-014 The decode fire condition is dec_valid_i && dec_ready_o.
REQ-015 dec_ready_o SHALL be (!ren_valid_o || dis_ready_i) && !flush_i && !(dec_rd_en_i && dec_rd_idx_i!=0 && fl_stall_i).
REQ-016 The effective rd-write flag is eff_rd = dec_rd_en_i && dec_rd_idx_i!=0.
REQ-017 fl_rdst_en_o SHALL equal fire && eff_rd, combinationally; fl_arc_rdst_idx_o SHALL equal dec_rd_idx_i.
REQ-018 Source lookups SHALL read spec_rat before the current instruction's own rd update, so that rs==rd returns the old mapping.
REQ-019 Index 0 SHALL always map to physical 0.
REQ-020 On fire with eff_rd: spec_rat[rd] <= fl_phy_rdst_idx_i; ren_old_phy_rd_o <= the prior spec_rat[rd].
REQ-021 Output registers SHALL load on fire with latency 1 cycle; ren_valid_o SHALL set on fire and clear when dis_ready_i is high without a new fire.
REQ-022 Outputs SHALL hold stable while ren_valid_o && !dis_ready_i.
REQ-023 On rob_retire_en_i: arch_rat[rob_retire_arc_i] <= rob_retire_phy_i; writes with arc==0 SHALL be ignored.
REQ-024 On flush_i:
- next cycle spec_rat SHALL equal arch_rat including any same-cycle retire update (forwarded);
- ren_valid_o SHALL be 0;
- no fire occurs that cycle.
REQ-025 Back-to-back fires SHALL be supported with no bubble (1 instruction per cycle) when dis_ready_i stays high.

Reset
REQ-026 On rst_i, every spec_rat and arch_rat entry SHALL be 0.
REQ-027 On rst_i, ren_valid_o SHALL be 0 and all ren_* data outputs SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard any in-flight output without a handshake.

Structure
REQ-029 PHY_REG_WTH and a ren_out_t struct (phy_rs1, phy_rs2, phy_rd, old_phy_rd, arc_rd, rd_en) SHALL reside in sy_pkg.
REQ-030 A single sub-module sy_ppl_rat_tbl SHALL implement one 32-entry map (1 write port, 3 read ports, bulk load), instanced for both spec_rat and arch_rat.

Verification
REQ-031 Reset, then rename x5 (rd_en=1), with the free list returning 31 -> ren_phy_rd_o=31, ren_old_phy_rd_o=0, ren_valid_o=1 next cycle.
REQ-032 Rename rs1=x5 on the cycle after REQ-031 -> ren_phy_rs1_o=31; then rd=x5 again with 30 -> old_phy=31.
REQ-033 fl_stall_i=1 with rd=x7 -> dec_ready_o=0 and fl_rdst_en_o=0; rd=x0 in the same condition -> fires, ren_rd_en_o=0, phy_rd=0.
REQ-034 dis_ready_i=0 for 3 cycles with ren_valid_o=1 -> outputs unchanged, dec_ready_o=0, no fl_rdst_en_o.
REQ-035 Retire x5->31, then flush with a same-cycle retire x6->29 -> lookups of x5 and x6 return 31 and 29; speculative mapping x5->30 is discarded.

Source files
------------

// File: rtl/sy_ppl_rat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sy_pkg
// Description : Shared widths and the rename output record for the register
//               alias table.
// Revision    : 1.0 - initial release
// ============================================================================
package sy_pkg;

    localparam int PHY_REG_NUM_DEF = 32;
    localparam int PHY_REG_WTH     = $clog2(PHY_REG_NUM_DEF);
    localparam int ARC_REG_NUM     = 32;
    localparam int ARC_REG_WTH     = 5;

    typedef logic [PHY_REG_WTH-1:0] phy_idx_t;
    typedef logic [ARC_REG_WTH-1:0] arc_idx_t;

    // One renamed instruction as presented to dispatch
    typedef struct packed {
        phy_idx_t phy_rs1;
        phy_idx_t phy_rs2;
        phy_idx_t phy_rd;
        phy_idx_t old_phy_rd;
        arc_idx_t arc_rd;
        logic     rd_en;
    } ren_out_t;

endpackage
`default_nettype wire

// File: rtl/sy_ppl_rat_if.sv
`default_nettype none
// ============================================================================
// Module      : sy_ppl_rat_if
// Description : Decode, free-list, dispatch and retire signals of the RAT.
//               slave = the RAT itself, master = its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface sy_ppl_rat_if;
    import sy_pkg::*;

    logic     flush_i;
    logic     dec_valid_i;
    logic     dec_ready_o;
    arc_idx_t dec_rs1_idx_i;
    arc_idx_t dec_rs2_idx_i;
    arc_idx_t dec_rd_idx_i;
    logic     dec_rd_en_i;
    logic     fl_rdst_en_o;
    arc_idx_t fl_arc_rdst_idx_o;
    phy_idx_t fl_phy_rdst_idx_i;
    logic     fl_stall_i;
    logic     ren_valid_o;
    logic     dis_ready_i;
    phy_idx_t ren_phy_rs1_o;
    phy_idx_t ren_phy_rs2_o;
    phy_idx_t ren_phy_rd_o;
    phy_idx_t ren_old_phy_rd_o;
    arc_idx_t ren_arc_rd_o;
    logic     ren_rd_en_o;
    logic     rob_retire_en_i;
    arc_idx_t rob_retire_arc_i;
    phy_idx_t rob_retire_phy_i;

    modport slave (
        input  flush_i, dec_valid_i, dec_rs1_idx_i, dec_rs2_idx_i, dec_rd_idx_i,
               dec_rd_en_i, fl_phy_rdst_idx_i, fl_stall_i, dis_ready_i,
               rob_retire_en_i, rob_retire_arc_i, rob_retire_phy_i,
        output dec_ready_o, fl_rdst_en_o, fl_arc_rdst_idx_o, ren_valid_o,
               ren_phy_rs1_o, ren_phy_rs2_o, ren_phy_rd_o, ren_old_phy_rd_o,
               ren_arc_rd_o, ren_rd_en_o
    );

    modport master (
        output flush_i, dec_valid_i, dec_rs1_idx_i, dec_rs2_idx_i, dec_rd_idx_i,
               dec_rd_en_i, fl_phy_rdst_idx_i, fl_stall_i, dis_ready_i,
               rob_retire_en_i, rob_retire_arc_i, rob_retire_phy_i,
        input  dec_ready_o, fl_rdst_en_o, fl_arc_rdst_idx_o, ren_valid_o,
               ren_phy_rs1_o, ren_phy_rs2_o, ren_phy_rd_o, ren_old_phy_rd_o,
               ren_arc_rd_o, ren_rd_en_o
    );

endinterface
`default_nettype wire

// File: rtl/sy_ppl_rat_tbl.sv
`default_nettype none
// ============================================================================
// Module      : sy_ppl_rat_tbl
// Description : 32-entry architectural-to-physical map with one write port,
//               three asynchronous read ports and a whole-table load.
//               Entry 0 is pinned to physical register 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sy_ppl_rat_tbl #(
    parameter int WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  load_i,
    input  logic [31:0][WIDTH-1:0] load_data_i,
    input  logic [4:0]            raddr0_i,
    input  logic [4:0]            raddr1_i,
    input  logic [4:0]            raddr2_i,
    output logic [WIDTH-1:0]      rdata0_o,
    output logic [WIDTH-1:0]      rdata1_o,
    output logic [WIDTH-1:0]      rdata2_o,
    output logic [31:0][WIDTH-1:0] entries_o
);

    logic [31:0][WIDTH-1:0] r_map;

    // Map storage: reset clears, bulk load wins over a single write, x0 never changes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_map <= '0;
        end else if (load_i) begin
            r_map[0] <= '0;
            for (int i = 1; i < 32; i++) begin
                r_map[i] <= load_data_i[i];
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            r_map[waddr_i] <= wdata_i;
        end
    end

    assign rdata0_o  = r_map[raddr0_i];
    assign rdata1_o  = r_map[raddr1_i];
    assign rdata2_o  = r_map[raddr2_i];
    assign entries_o = r_map;

endmodule
`default_nettype wire

// File: rtl/sy_ppl_rat.sv
`default_nettype none
// ============================================================================
// Module      : sy_ppl_rat
// Description : Register alias table. Renames one decoded instruction per
//               cycle through a speculative map, tracks committed mappings in
//               an architectural map and restores the former from the latter
//               on flush.
// Revision    : 1.0 - initial release
// ============================================================================
module sy_ppl_rat
    import sy_pkg::*;
#(
    parameter int PHY_REG_NUM = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    sy_ppl_rat_if.slave rat
);

    // Must agree with sy_pkg::PHY_REG_WTH, which sizes the interface fields
    localparam int RAT_W = $clog2(PHY_REG_NUM);

    logic                   w_eff_rd;
    logic                   w_ready;
    logic                   w_fire;
    logic [RAT_W-1:0]       w_rs1_map;
    logic [RAT_W-1:0]       w_rs2_map;
    logic [RAT_W-1:0]       w_old_map;
    logic [31:0][RAT_W-1:0] w_arch_map;
    logic [31:0][RAT_W-1:0] w_flush_map;
    logic [31:0][RAT_W-1:0] w_unused_spec_entries;
    logic [RAT_W-1:0]       w_unused_arch_rd0;
    logic [RAT_W-1:0]       w_unused_arch_rd1;
    logic [RAT_W-1:0]       w_unused_arch_rd2;
    ren_out_t               w_next;
    ren_out_t               r_out;
    logic                   r_valid;

    // x0 is hard-wired, so a write to it needs no physical register
    assign w_eff_rd = rat.dec_rd_en_i && (rat.dec_rd_idx_i != 5'd0);
    assign w_ready  = (!r_valid || rat.dis_ready_i) && !rat.flush_i
                      && !(w_eff_rd && rat.fl_stall_i);
    assign w_fire   = rat.dec_valid_i && w_ready;

    assign rat.dec_ready_o       = w_ready;
    assign rat.fl_rdst_en_o      = w_fire && w_eff_rd;
    assign rat.fl_arc_rdst_idx_o = rat.dec_rd_idx_i;

    // Restore image for flush: committed map with this cycle's retire forwarded in
    for (genvar i = 0; i < 32; i++) begin : g_fwd
        assign w_flush_map[i] = (rat.rob_retire_en_i && (rat.rob_retire_arc_i == 5'(i)))
                                ? rat.rob_retire_phy_i : w_arch_map[i];
    end

    // Port 2 reads rd before its own update, giving the mapping being replaced
    sy_ppl_rat_tbl #(.WIDTH(RAT_W)) u_spec_rat (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .we_i        (w_fire && w_eff_rd),
        .waddr_i     (rat.dec_rd_idx_i),
        .wdata_i     (rat.fl_phy_rdst_idx_i),
        .load_i      (rat.flush_i),
        .load_data_i (w_flush_map),
        .raddr0_i    (rat.dec_rs1_idx_i),
        .raddr1_i    (rat.dec_rs2_idx_i),
        .raddr2_i    (rat.dec_rd_idx_i),
        .rdata0_o    (w_rs1_map),
        .rdata1_o    (w_rs2_map),
        .rdata2_o    (w_old_map),
        .entries_o   (w_unused_spec_entries)
    );

    sy_ppl_rat_tbl #(.WIDTH(RAT_W)) u_arch_rat (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .we_i        (rat.rob_retire_en_i),
        .waddr_i     (rat.rob_retire_arc_i),
        .wdata_i     (rat.rob_retire_phy_i),
        .load_i      (1'b0),
        .load_data_i ('0),
        .raddr0_i    (5'd0),
        .raddr1_i    (5'd0),
        .raddr2_i    (5'd0),
        .rdata0_o    (w_unused_arch_rd0),
        .rdata1_o    (w_unused_arch_rd1),
        .rdata2_o    (w_unused_arch_rd2),
        .entries_o   (w_arch_map)
    );

    // Assemble the renamed record; destination fields are zero when rd is not written
    always_comb begin
        w_next            = '0;
        w_next.phy_rs1    = w_rs1_map;
        w_next.phy_rs2    = w_rs2_map;
        w_next.phy_rd     = w_eff_rd ? rat.fl_phy_rdst_idx_i : '0;
        w_next.old_phy_rd = w_eff_rd ? w_old_map : '0;
        w_next.arc_rd     = rat.dec_rd_idx_i;
        w_next.rd_en      = w_eff_rd;
    end

    // Dispatch output stage: load on fire, hold under back-pressure, drop on flush
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else if (rat.flush_i) begin
            r_valid <= 1'b0;
        end else if (w_fire) begin
            r_out   <= w_next;
            r_valid <= 1'b1;
        end else if (rat.dis_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign rat.ren_valid_o      = r_valid;
    assign rat.ren_phy_rs1_o    = r_out.phy_rs1;
    assign rat.ren_phy_rs2_o    = r_out.phy_rs2;
    assign rat.ren_phy_rd_o     = r_out.phy_rd;
    assign rat.ren_old_phy_rd_o = r_out.old_phy_rd;
    assign rat.ren_arc_rd_o     = r_out.arc_rd;
    assign rat.ren_rd_en_o      = r_out.rd_en;

endmodule
`default_nettype wire
